// File: rtl/shift_sched.sv
// Two-port shift scheduler: one shared barrel shifter feeding a single result register.
// Define SHIFT_SCHED_RR_EN for round-robin arbitration; fixed priority (port 0) otherwise.
module shift_sched #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_data,
  input  logic [4:0]       req0_shamt,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_data,
  input  logic [4:0]       req1_shamt,
  input  logic             req1_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_id,
  output logic [CNT_W-1:0] done0_cnt,
  output logic [CNT_W-1:0] done1_cnt
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [31:0]      data_q, data_d;
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  logic accept;
  logic gnt0, gnt1;
  logic fire;
  logic deliver;

  logic [31:0] sh_in;
  logic [4:0]  sh_amt;
  logic        sh_op;
  logic        sgn;
  logic [31:0] s1, s2, s3, s4, s5;

`ifdef SHIFT_SCHED_RR_EN
  logic ptr_q, ptr_d;
`endif

  // Arbitration never looks at operand data, only valids/state/pointer.
  always_comb begin
    accept = (state_q == EMPTY) | out_ready;
`ifdef SHIFT_SCHED_RR_EN
    gnt1 = req1_valid & (~req0_valid | ptr_q);
`else
    gnt1 = req1_valid & ~req0_valid;
`endif
    gnt0 = req0_valid & ~gnt1;
    fire = accept & (gnt0 | gnt1);
    req0_ready = reset_n & accept & gnt0;
    req1_ready = reset_n & accept & gnt1;
  end

  always_comb begin
    sh_in  = gnt1 ? req1_data  : req0_data;
    sh_amt = gnt1 ? req1_shamt : req0_shamt;
    sh_op  = gnt1 ? req1_op    : req0_op;
    sgn    = sh_in[31];
  end

  // Five log stages; op=1 is arithmetic right, op=0 logical left.
  always_comb begin
    if (!sh_amt[0])  s1 = sh_in;
    else if (sh_op)  s1 = {sgn, sh_in[31:1]};
    else             s1 = {sh_in[30:0], 1'b0};

    if (!sh_amt[1])  s2 = s1;
    else if (sh_op)  s2 = {{2{sgn}}, s1[31:2]};
    else             s2 = {s1[29:0], 2'b0};

    if (!sh_amt[2])  s3 = s2;
    else if (sh_op)  s3 = {{4{sgn}}, s2[31:4]};
    else             s3 = {s2[27:0], 4'b0};

    if (!sh_amt[3])  s4 = s3;
    else if (sh_op)  s4 = {{8{sgn}}, s3[31:8]};
    else             s4 = {s3[23:0], 8'b0};

    if (!sh_amt[4])  s5 = s4;
    else if (sh_op)  s5 = {{16{sgn}}, s4[31:16]};
    else             s5 = {s4[15:0], 16'b0};
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    id_d    = id_q;
    deliver = (state_q == FULL) & out_ready;
    unique case (state_q)
      EMPTY: begin
        if (fire) state_d = FULL;
      end
      FULL: begin
        if (fire)           state_d = FULL;
        else if (out_ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (fire) begin
      data_d = s5;
      id_d   = gnt1;
    end
  end

  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (deliver && !id_q) cnt0_d = cnt0_q + CNT_W'(1);
    if (deliver &&  id_q) cnt1_d = cnt1_q + CNT_W'(1);
  end

`ifdef SHIFT_SCHED_RR_EN
  always_comb begin
    ptr_d = ptr_q;
    if (fire) ptr_d = gnt0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      id_q    <= 1'b0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign done0_cnt = cnt0_q;
  assign done1_cnt = cnt1_q;

endmodule

// File: doc/shift_sched.md
SHIFT_SCHED -- requirements
Module: shift_sched

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each per-port completion counter.
REQ-002 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each, requester has an operation pending.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1 each, operation accepted this cycle when valid&ready.
REQ-006 SHALL have ports req0_data/req1_data, input, 32 each, operand.
REQ-007 SHALL have ports req0_shamt/req1_shamt, input, 5 each, shift amount 0..31.
REQ-008 SHALL have ports req0_op/req1_op, input, 1 each, 0 = logical left, 1 = arithmetic right.
REQ-009 SHALL have port out_valid, output, 1, result register holds a valid result.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result when out_valid&out_ready.
REQ-011 SHALL have port out_data, output, 32, registered shift result.
REQ-012 SHALL have port out_id, output, 1, index of the requester that owns out_data.
REQ-013 SHALL have ports done0_cnt/done1_cnt, output, CNT_W each, count of results delivered per requester.

Function
REQ-014 SHALL share one 32-bit shift datapath, with five 1/2/4/8/16 stages selected by shamt bits, between the two requesters.
REQ-015 SHALL implement an arithmetic right shift that fills vacated MSBs with data[31], and a left shift that fills vacated LSBs with 0.
REQ-016 SHALL use a two-state FSM, EMPTY/FULL, representing occupancy of the result register.
REQ-017 SHALL define accept = EMPTY, or FULL & out_ready (drain and refill in the same cycle).
REQ-018 SHALL, when accept is high, assert at most one reqN_ready, and only to the granted valid requester.
REQ-019 SHALL keep reqN_ready combinational from valid/state/pointer, and SHALL never make it depend on reqN_data.
REQ-020 SHALL capture the result and id into the output register on the accepting edge; latency from handshake to out_valid = 1 cycle.
REQ-021 SHALL make transitions as follows: EMPTY->FULL on a grant; FULL->EMPTY on out_ready with no grant; FULL->FULL on out_ready with a grant, or on no out_ready.
REQ-022 SHALL hold out_data, out_id and out_valid stable while out_valid & !out_ready.
REQ-023 SHALL increment doneN_cnt on each out_valid&out_ready with out_id = N, wrapping from all-ones to 0.
REQ-024 SHALL, for shamt = 0, return data unchanged for both ops.
REQ-025 SHALL, when no request is valid and accept is high, leave state and outputs unchanged except that a drain moves the FSM to EMPTY.

Reset
REQ-026 SHALL, while reset_n is low, asynchronously force state EMPTY, out_valid 0, out_data 0, out_id 0, done counters 0, RR pointer 0.
REQ-027 SHALL discard an in-flight result when reset asserts mid-operation, and SHALL not count it.
REQ-028 SHALL hold all ready outputs 0 while reset_n is low.

Configuration
REQ-029 SHALL, with SHIFT_SCHED_RR_EN defined, arbitrate round-robin: on simultaneous valid, grant the port the pointer names, then set the pointer to the other port after each grant.
REQ-030 SHALL, without SHIFT_SCHED_RR_EN, use fixed priority (port 0 wins on simultaneous valid) and SHALL omit the pointer flop.

Verification
REQ-031 SHALL cover: req0 sra data=0x80000000 shamt=4, out_ready=1 -> next cycle out_valid=1, out_data=0xF8000000, out_id=0, done0_cnt=1.
REQ-032 SHALL cover: req1 sll data=0x00000001 shamt=31 -> out_data=0x80000000, out_id=1; sra 0x7FFFFFFF shamt=31 -> 0x00000000.
REQ-033 SHALL cover: out_ready=0 for 5 cycles with result held -> out_data/out_id stable, both ready=0; out_ready=1 with req0 valid -> drain and accept in the same cycle, out_valid stays 1.
REQ-034 SHALL cover: both valid for 4 back-to-back ops, out_ready=1 -> ids 0,1,0,1 with RR_EN, ids 0,0,0,0 without it.
REQ-035 SHALL cover: reset_n pulsed low while FULL -> out_valid=0 immediately, counters 0, and no counter increment after release.
REQ-036 SHALL cover: 2^CNT_W+1 deliveries to port 0 (CNT_W=4 -> 17) -> done0_cnt wraps to 1.
